// File: rtl/clint_resp.sv
// Core-local interruptor: memory-mapped msip / mtime / mtimecmp on the core's data port,
// driving the timer and software interrupt lines.
module clint_resp #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0200_0000,
    parameter int                    TICK_DIV   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_request_i,
    input  logic                  ram_we_i,
    input  logic [3:0]            ram_op_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_wdata_i,
    output logic [DATA_WIDTH-1:0] ram_rdata_o,
    output logic                  hit_o,
    output logic                  timer_irq_o,
    output logic                  software_irq_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [13:0] IDX_MSIP    = 14'h0000;
    localparam logic [13:0] IDX_CMP_LO  = 14'h1000;
    localparam logic [13:0] IDX_CMP_HI  = 14'h1001;
    localparam logic [13:0] IDX_TIME_LO = 14'h2FFE;
    localparam logic [13:0] IDX_TIME_HI = 14'h2FFF;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          tick;
    logic [63:0]   mtime;
    logic [63:0]   time_next;
    logic [63:0]   mtimecmp;
    logic [63:0]   cmp_next;
    logic          msip;
    logic          msip_next;
    logic [13:0]   word_idx;
    logic [3:0]    be;
    logic          wr_en;
    logic          rd_en;
    logic          unused_op;

    assign unused_op = ^ram_op_i[3:2];

    // Lane enables from access size and low address bits; misaligned half/word yields none.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] low);
        case (size)
            2'b00:   return 4'b0001 << low;
            2'b01:   return low[0] ? 4'b0000 : (low[1] ? 4'b1100 : 4'b0011);
            default: return (low == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] en);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = en[i] ? data[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    assign hit_o    = ram_request_i & (ram_addr_i[ADDR_WIDTH-1:16] == BASE_ADDR[ADDR_WIDTH-1:16]);
    assign word_idx = ram_addr_i[15:2];
    assign be       = byte_en(ram_op_i[1:0], ram_addr_i[1:0]);
    assign wr_en    = hit_o & ram_we_i & (be != 4'b0000);
    assign rd_en    = hit_o & ~ram_we_i;

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign presc_next = tick ? '0 : presc + 1'b1;

    // A bus write to an mtime half overrides the tick entirely, carry included.
    always_comb begin
        msip_next = msip;
        cmp_next  = mtimecmp;
        time_next = tick ? mtime + 64'd1 : mtime;
        if (wr_en) begin
            case (word_idx)
                IDX_MSIP:    msip_next = be[0] ? ram_wdata_i[0] : msip;
                IDX_CMP_LO:  cmp_next  = {mtimecmp[63:32], merge(mtimecmp[31:0], ram_wdata_i, be)};
                IDX_CMP_HI:  cmp_next  = {merge(mtimecmp[63:32], ram_wdata_i, be), mtimecmp[31:0]};
                IDX_TIME_LO: time_next = {mtime[63:32], merge(mtime[31:0], ram_wdata_i, be)};
                IDX_TIME_HI: time_next = {merge(mtime[63:32], ram_wdata_i, be), mtime[31:0]};
                default:     ;
            endcase
        end
    end

    always_comb begin
        ram_rdata_o = '0;
        if (rd_en) begin
            case (word_idx)
                IDX_MSIP:    ram_rdata_o = {31'b0, msip};
                IDX_CMP_LO:  ram_rdata_o = mtimecmp[31:0];
                IDX_CMP_HI:  ram_rdata_o = mtimecmp[63:32];
                IDX_TIME_LO: ram_rdata_o = mtime[31:0];
                IDX_TIME_HI: ram_rdata_o = mtime[63:32];
                default:     ram_rdata_o = '0;
            endcase
        end
    end

    // The irq compare uses next-state values so it moves on the same edge as the registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc          <= '0;
            mtime          <= '0;
            mtimecmp       <= '1;
            msip           <= 1'b0;
            timer_irq_o    <= 1'b0;
            software_irq_o <= 1'b0;
        end else begin
            presc          <= presc_next;
            mtime          <= time_next;
            mtimecmp       <= cmp_next;
            msip           <= msip_next;
            timer_irq_o    <= (time_next >= cmp_next);
            software_irq_o <= msip;
        end
    end

endmodule
